lsu_bus_demux: RTL and testbench

//   Routes one load/store request from the core's data port to one of two targets (data RAM, MMIO),

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_addr_decode.sv | 33 +++
 rtl/lsu_bus_demux.sv | 193 +++++++++++++++++++
 tb/tb_lsu_bus_demux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default address map for the LSU bus demultiplexer.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RSP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_IO   = 2'd2
  } tgt_e;

  localparam logic [31:0] LSU_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LSU_RAM_MASK = 32'hF000_0000;
  localparam logic [31:0] LSU_IO_BASE  = 32'h1000_0000;
  localparam logic [31:0] LSU_IO_MASK  = 32'hF000_0000;

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational address decode: maps a byte address onto a target region.
module lsu_addr_decode
  import lsu_pkg::*;
#(
  parameter int                   P_ADDR_W   = 32,
  parameter logic [P_ADDR_W-1:0]  P_RAM_BASE = LSU_RAM_BASE,
  parameter logic [P_ADDR_W-1:0]  P_RAM_MASK = LSU_RAM_MASK,
  parameter logic [P_ADDR_W-1:0]  P_IO_BASE  = LSU_IO_BASE,
  parameter logic [P_ADDR_W-1:0]  P_IO_MASK  = LSU_IO_MASK
) (
  input  logic [P_ADDR_W-1:0] addr,
  output tgt_e                tgt
);

  logic ram_hit_s;
  logic io_hit_s;

  assign ram_hit_s = ((addr & P_RAM_MASK) == P_RAM_BASE);
  assign io_hit_s  = ((addr & P_IO_MASK) == P_IO_BASE);

  // RAM wins when the two regions overlap.
  always_comb begin
    tgt = TGT_NONE;
    if (ram_hit_s) begin
      tgt = TGT_RAM;
    end else if (io_hit_s) begin
      tgt = TGT_IO;
    end else begin
      tgt = TGT_NONE;
    end
  end

endmodule

// File: rtl/lsu_bus_demux.sv
// Routes one LSU request to RAM or MMIO and returns the selected target's
// response; one transaction outstanding, all outputs registered.
module lsu_bus_demux
  import lsu_pkg::*;
#(
  parameter int                   P_ADDR_W   = 32,
  parameter int                   P_DATA_W   = 32,
  parameter logic [P_ADDR_W-1:0]  P_RAM_BASE = LSU_RAM_BASE,
  parameter logic [P_ADDR_W-1:0]  P_RAM_MASK = LSU_RAM_MASK,
  parameter logic [P_ADDR_W-1:0]  P_IO_BASE  = LSU_IO_BASE,
  parameter logic [P_ADDR_W-1:0]  P_IO_MASK  = LSU_IO_MASK,
  parameter int                   P_TIMEOUT  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [P_ADDR_W-1:0]     i_req_addr,
  input  logic [P_DATA_W-1:0]     i_req_wdata,
  input  logic                    i_req_we,
  input  logic [P_DATA_W/8-1:0]   i_req_be,
  output logic                    o_rsp_valid,
  output logic [P_DATA_W-1:0]     o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [P_ADDR_W-1:0]     o_tgt_addr,
  output logic [P_DATA_W-1:0]     o_tgt_wdata,
  output logic                    o_tgt_we,
  output logic [P_DATA_W/8-1:0]   o_tgt_be,
  output logic                    o_ram_valid,
  input  logic                    i_ram_ready,
  input  logic                    i_ram_rvalid,
  input  logic [P_DATA_W-1:0]     i_ram_rdata,
  output logic                    o_io_valid,
  input  logic                    i_io_ready,
  input  logic                    i_io_rvalid,
  input  logic [P_DATA_W-1:0]     i_io_rdata
);

  localparam int BE_W  = P_DATA_W / 8;
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_r;
  tgt_e                sel_r;
  logic [CNT_W-1:0]    cnt_r;
  tgt_e                dec_tgt_s;
  logic                sel_ready_s;
  logic                sel_rvalid_s;
  logic [P_DATA_W-1:0] sel_rdata_s;
  logic                timeout_s;

  lsu_addr_decode #(
    .P_ADDR_W   (P_ADDR_W),
    .P_RAM_BASE (P_RAM_BASE),
    .P_RAM_MASK (P_RAM_MASK),
    .P_IO_BASE  (P_IO_BASE),
    .P_IO_MASK  (P_IO_MASK)
  ) u_decode (
    .addr (i_req_addr),
    .tgt  (dec_tgt_s)
  );

  // Only the latched target's handshake and data are ever observed.
  always_comb begin
    sel_ready_s  = 1'b0;
    sel_rvalid_s = 1'b0;
    sel_rdata_s  = {P_DATA_W{1'b0}};
    case (sel_r)
      TGT_RAM: begin
        sel_ready_s  = i_ram_ready;
        sel_rvalid_s = i_ram_rvalid;
        sel_rdata_s  = i_ram_rdata;
      end
      TGT_IO: begin
        sel_ready_s  = i_io_ready;
        sel_rvalid_s = i_io_rvalid;
        sel_rdata_s  = i_io_rdata;
      end
      default: begin
        sel_ready_s  = 1'b0;
        sel_rvalid_s = 1'b0;
        sel_rdata_s  = {P_DATA_W{1'b0}};
      end
    endcase
  end

  // Last permitted cycle in ISSUE/WAIT: counter runs 0..P_TIMEOUT-1.
  assign timeout_s = (cnt_r == CNT_LAST);

  // Transaction FSM with registered request, response and target strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= S_IDLE;
      sel_r       <= TGT_NONE;
      cnt_r       <= {CNT_W{1'b0}};
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= {P_DATA_W{1'b0}};
      o_rsp_err   <= 1'b0;
      o_tgt_addr  <= {P_ADDR_W{1'b0}};
      o_tgt_wdata <= {P_DATA_W{1'b0}};
      o_tgt_we    <= 1'b0;
      o_tgt_be    <= {BE_W{1'b0}};
      o_ram_valid <= 1'b0;
      o_io_valid  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= {P_DATA_W{1'b0}};
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            o_tgt_addr  <= i_req_addr;
            o_tgt_wdata <= i_req_wdata;
            o_tgt_we    <= i_req_we;
            o_tgt_be    <= i_req_be;
            sel_r       <= dec_tgt_s;
            cnt_r       <= {CNT_W{1'b0}};
            case (dec_tgt_s)
              TGT_RAM: begin
                o_ram_valid <= 1'b1;
                state_r     <= S_ISSUE;
              end
              TGT_IO: begin
                o_io_valid <= 1'b1;
                state_r    <= S_ISSUE;
              end
              default: begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b1;
                state_r     <= S_RSP;
              end
            endcase
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (timeout_s) begin
            o_ram_valid <= 1'b0;
            o_io_valid  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= {P_DATA_W{1'b0}};
            state_r     <= S_RSP;
          end else if (sel_ready_s) begin
            o_ram_valid <= 1'b0;
            o_io_valid  <= 1'b0;
            state_r     <= S_WAIT;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r + CNT_ONE;
          // A response arriving on the final cycle still beats the timeout.
          if (sel_rvalid_s) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= o_tgt_we ? {P_DATA_W{1'b0}} : sel_rdata_s;
            state_r     <= S_RSP;
          end else if (timeout_s) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= {P_DATA_W{1'b0}};
            state_r     <= S_RSP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_RSP: begin
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= {P_DATA_W{1'b0}};
          o_req_ready <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_ram_valid <= 1'b0;
          o_io_valid  <= 1'b0;
          o_req_ready <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_demux.sv
// Directed, table-driven bench for lsu_bus_demux with hand-computed expectations.
module tb_lsu_bus_demux;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [3:0]  i_req_be;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_tgt_addr;
  logic [31:0] o_tgt_wdata;
  logic        o_tgt_we;
  logic [3:0]  o_tgt_be;
  logic        o_ram_valid;
  logic        i_ram_ready;
  logic        i_ram_rvalid;
  logic [31:0] i_ram_rdata;
  logic        o_io_valid;
  logic        i_io_ready;
  logic        i_io_rvalid;
  logic [31:0] i_io_rdata;

  int passed = 0;
  int total  = 0;

  always #5 i_clk = ~i_clk;

  lsu_bus_demux dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_we(i_req_we), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_tgt_addr(o_tgt_addr), .o_tgt_wdata(o_tgt_wdata),
    .o_tgt_we(o_tgt_we), .o_tgt_be(o_tgt_be),
    .o_ram_valid(o_ram_valid), .i_ram_ready(i_ram_ready),
    .i_ram_rvalid(i_ram_rvalid), .i_ram_rdata(i_ram_rdata),
    .o_io_valid(o_io_valid), .i_io_ready(i_io_ready),
    .i_io_rvalid(i_io_rvalid), .i_io_rdata(i_io_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          tgt;      // 0 none, 1 ram, 2 io
    int          rdy_dly;  // valid cycles before target raises ready
    int          rv_dly;   // cycles after handshake before rvalid, -1 never
    logic [31:0] rdata;
    int          exp_lat;  // cycle of o_rsp_valid, accept edge ends cycle 0
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic clear_tgt_inputs();
    i_ram_ready  = 1'b0;
    i_ram_rvalid = 1'b0;
    i_io_ready   = 1'b0;
    i_io_rvalid  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   vcnt = 0;
    int   h    = 0;
    bit   hs   = 1'b0;
    int   lat  = -1;
    bit   wrong = 1'b0;
    bit   rdy_bad = 1'b0;
    bit   tgt_bad = 1'b0;
    logic sel_v;
    logic oth_v;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = 32'h0;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    i_req_we    = v.we;
    i_req_be    = v.be;
    for (int t = 1; t <= 40 && lat < 0; t++) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      clear_tgt_inputs();
      if (o_rsp_valid) begin
        lat       = t;
        got_err   = o_rsp_err;
        got_rdata = o_rsp_rdata;
      end else begin
        if (o_req_ready) rdy_bad = 1'b1;
        sel_v = (v.tgt == 1) ? o_ram_valid : (v.tgt == 2) ? o_io_valid : 1'b0;
        oth_v = (v.tgt == 1) ? o_io_valid : (v.tgt == 2) ? o_ram_valid : (o_ram_valid | o_io_valid);
        if (oth_v) wrong = 1'b1;
        if (sel_v && (o_tgt_addr !== v.addr || o_tgt_wdata !== v.wdata ||
                      o_tgt_we !== v.we || o_tgt_be !== v.be)) tgt_bad = 1'b1;
        if (sel_v && !hs) begin
          if (vcnt == v.rdy_dly) begin
            if (v.tgt == 1) i_ram_ready = 1'b1; else i_io_ready = 1'b1;
            hs = 1'b1;
            h  = t;
          end
          vcnt++;
        end
        if (hs && v.rv_dly >= 0 && t == h + 1 + v.rv_dly) begin
          if (v.tgt == 1) begin
            i_ram_rvalid = 1'b1;
            i_ram_rdata  = v.rdata;
          end else begin
            i_io_rvalid = 1'b1;
            i_io_rdata  = v.rdata;
          end
        end
      end
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d err", idx), 64'(got_err), 64'(v.exp_err));
    chk($sformatf("v%0d rdata", idx), 64'(got_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d other_valid", idx), 64'(wrong), 64'd0);
    chk($sformatf("v%0d req_ready_busy", idx), 64'(rdy_bad), 64'd0);
    chk($sformatf("v%0d tgt_stable", idx), 64'(tgt_bad), 64'd0);
    @(negedge i_clk);
    chk($sformatf("v%0d rsp_one_cycle", idx), 64'({o_rsp_valid, o_req_ready}), 64'b01);
  endtask

  initial begin
    int pulses;
    bit bad;
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr = 32'h0;
    i_req_wdata = 32'h0;
    i_req_we = 1'b0;
    i_req_be = 4'h0;
    i_ram_rdata = 32'h0;
    i_io_rdata = 32'h0;
    clear_tgt_inputs();

    //                addr          wdata         we    be    tgt rdy rv  rdata         lat err   exp_rdata
    vecs[0] = '{32'h0000_0040, 32'h0000_0000, 1'b0, 4'hF, 1,  0,  0, 32'hDEAD_BEEF, 3,  1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h1000_0004, 32'h0000_0055, 1'b1, 4'h1, 2,  3,  0, 32'hFFFF_FFFF, 6,  1'b0, 32'h0000_0000};
    vecs[2] = '{32'h2000_0000, 32'h0000_0000, 1'b0, 4'hF, 0,  0,  0, 32'h0000_0000, 1,  1'b1, 32'h0000_0000};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000, 1'b0, 4'hF, 1,  0, -1, 32'h0000_0000, 17, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h1000_0010, 32'h0000_0000, 1'b0, 4'hF, 2,  1,  2, 32'h1234_5678, 6,  1'b0, 32'h1234_5678};
    vecs[5] = '{32'hF000_0000, 32'h0000_0000, 1'b0, 4'hF, 0,  0,  0, 32'h0000_0000, 1,  1'b1, 32'h0000_0000};
    vecs[6] = '{32'h0FFF_FFFC, 32'h0000_A5A5, 1'b1, 4'hF, 1,  0,  1, 32'h0000_0011, 4,  1'b0, 32'h0000_0000};
    vecs[7] = '{32'h1FFF_FFF0, 32'h0000_0000, 1'b0, 4'h3, 2, 99,  0, 32'h0000_0000, 17, 1'b1, 32'h0000_0000};

    repeat (2) @(negedge i_clk);
    chk("rst req_ready", 64'(o_req_ready), 64'd1);
    chk("rst rsp", 64'({o_rsp_valid, o_rsp_err, o_rsp_rdata}), 64'd0);
    chk("rst tgt_valid", 64'({o_ram_valid, o_io_valid}), 64'd0);
    chk("rst tgt_bus", 64'({o_tgt_we, o_tgt_be, o_tgt_addr}), 64'd0);
    chk("rst tgt_wdata", 64'(o_tgt_wdata), 64'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Spurious MMIO rvalid during RAM WAIT, then reset aborts the transaction.
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0080;
    i_req_we    = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_ram_ready = 1'b1;
    @(negedge i_clk);
    i_ram_ready = 1'b0;
    i_io_rvalid = 1'b1;
    i_io_rdata  = 32'hBAD0_BAD0;
    @(negedge i_clk);
    chk("spurious io_rvalid", 64'({o_rsp_valid, o_req_ready}), 64'd0);
    i_io_rvalid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst ready_rsp", 64'({o_req_ready, o_rsp_valid, o_rsp_err}), 64'b100);
    chk("midrst tgt", 64'({o_ram_valid, o_io_valid, o_tgt_addr}), 64'd0);
    i_rst = 1'b0;
    i_ram_rvalid = 1'b1;
    i_ram_rdata  = 32'h7777_7777;
    bad = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge i_clk);
      i_ram_rvalid = 1'b0;
      if (o_rsp_valid || !o_req_ready) bad = 1'b1;
    end
    chk("late rvalid ignored", 64'(bad), 64'd0);

    // Back-to-back RAM loads against an always-ready, always-responding RAM.
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h0000_0100;
    i_ram_ready  = 1'b1;
    i_ram_rvalid = 1'b1;
    i_ram_rdata  = 32'hCAFE_F00D;
    pulses = 0;
    bad = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        pulses++;
        if ((t % 4) != 3 || o_rsp_rdata !== 32'hCAFE_F00D) bad = 1'b1;
      end
    end
    i_req_valid = 1'b0;
    clear_tgt_inputs();
    chk("b2b pulse count", 64'(pulses), 64'd3);
    chk("b2b pulse timing", 64'(bad), 64'd0);
    repeat (4) @(negedge i_clk);
    chk("b2b idle", 64'({o_req_ready, o_rsp_valid}), 64'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
